// File: rtl/activity_led_monitor_if.sv
// Signal bundle between the core-side activity sources and the LED monitor.
// master drives enables, watched signals and mode; slave returns activity and LED drive.
interface activity_led_monitor_if #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned WIDTH    = 2
);
    localparam int unsigned CH_W = $clog2(CHANNELS) + 1;

    logic [CHANNELS-1:0]       en;
    logic [CHANNELS*WIDTH-1:0] watch;
    logic                      mode;
    logic [CHANNELS-1:0]       act;
    logic                      led;
    logic [CH_W-1:0]           led_ch;

    modport master (
        output en, watch, mode,
        input  act, led, led_ch
    );

    modport slave (
        input  en, watch, mode,
        output act, led, led_ch
    );
endinterface

// File: rtl/activity_led_monitor.sv
// Multi-channel activity detector: any toggle on a channel's watched bundle holds its
// activity flag for TIMEOUT cycles; channels combine into one solid or blinking LED.
module activity_led_monitor #(
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned WIDTH     = 2,
    parameter int unsigned TIMEOUT   = 1000000,
    parameter int unsigned BLINK_DIV = 2800000,
    parameter int unsigned CW        = $clog2(TIMEOUT + 1)
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    activity_led_monitor_if.slave bus
);
    localparam int unsigned CH_W = $clog2(CHANNELS) + 1;
    localparam int unsigned DW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
    localparam logic [DW-1:0] DIV_LAST  = DW'(BLINK_DIV - 1);

    logic [CHANNELS*WIDTH-1:0] prev_q;
    logic                      primed_q;
    logic [CW-1:0]             cnt_q    [CHANNELS];
    logic [CW-1:0]             cnt_next [CHANNELS];
    logic [CHANNELS-1:0]       toggle_c;
    logic [CHANNELS-1:0]       act_q;
    logic [CHANNELS-1:0]       act_next;
    logic [DW-1:0]             div_q;
    logic [DW-1:0]             div_next;
    logic                      phase_q;
    logic                      phase_next;
    logic                      led_q;
    logic                      led_next;
    logic [CH_W-1:0]           led_ch_q;
    logic [CH_W-1:0]           led_ch_next;

    // Per-channel retrigger / countdown; disable has priority over a toggle
    always_comb begin
        toggle_c = '0;
        cnt_next = cnt_q;
        act_next = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            toggle_c[c] = primed_q & bus.en[c] &
                          (|(bus.watch[c*WIDTH +: WIDTH] ^ prev_q[c*WIDTH +: WIDTH]));
            if (!bus.en[c]) begin
                cnt_next[c] = '0;
            end else if (toggle_c[c]) begin
                cnt_next[c] = TIMEOUT_C;
            end else if (cnt_q[c] != '0) begin
                cnt_next[c] = cnt_q[c] - CW'(1);
            end
            act_next[c] = (cnt_next[c] != '0);
        end
    end

    // Blink divider runs only while something is already active, so new activity lights at once
    always_comb begin
        div_next   = '0;
        phase_next = 1'b1;
        if (|act_q) begin
            if (div_q == DIV_LAST) begin
                div_next   = '0;
                phase_next = ~phase_q;
            end else begin
                div_next   = div_q + DW'(1);
                phase_next = phase_q;
            end
        end
    end

    // LED drive and lowest active channel index, aligned with act
    always_comb begin
        led_next    = (|act_next) & (bus.mode ? phase_next : 1'b1);
        led_ch_next = '0;
        for (int c = int'(CHANNELS) - 1; c >= 0; c--) begin
            if (act_next[c]) begin
                led_ch_next = CH_W'(c);
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            prev_q   <= '0;
            primed_q <= 1'b0;
            for (int c = 0; c < int'(CHANNELS); c++) begin
                cnt_q[c] <= '0;
            end
            act_q    <= '0;
            div_q    <= '0;
            phase_q  <= 1'b1;
            led_q    <= 1'b0;
            led_ch_q <= '0;
        end else begin
            prev_q   <= bus.watch;
            primed_q <= 1'b1;
            cnt_q    <= cnt_next;
            act_q    <= act_next;
            div_q    <= div_next;
            phase_q  <= phase_next;
            led_q    <= led_next;
            led_ch_q <= led_ch_next;
        end
    end

    assign bus.act    = act_q;
    assign bus.led    = led_q;
    assign bus.led_ch = led_ch_q;

endmodule
